// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: FSM state encodings,
// default widths common with the processor, and the address range check.
package data_mem_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // An address is implemented when it lies below the configured depth.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the processor (MAR/MDR/strobe) and the
// data-memory controller.
interface data_mem_ctrl_if
  import data_mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (output req, we, addr, wdata, input rdata, ack, err, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err, busy);
endinterface

// File: rtl/data_mem_ctrl_sram_array.sv
// DEPTH x DATA_W synchronous SRAM: registered write, registered read, no
// reset so contents survive a controller reset.
module sram_array
  import data_mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] q_r;

  // Array write and read-port register; the read value holds until the next read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[idx] <= wdata;
    end
    if (re) begin
      q_r <= mem_r[idx];
    end
  end

  assign rdata = q_r;
endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked data-memory controller: captures a request, optionally waits
// WAIT_STATES cycles, then performs one array access and pulses ack.
// Out-of-range addresses are reported with err and never touch the array.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input logic            clk,
  input logic            res,
  data_mem_ctrl_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              we_r, we_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic              ack_r, ack_s;
  logic              err_r, err_s;
  logic              busy_r, busy_s;
  logic              rd_zero_r, rd_zero_s;
  logic              mem_we_s, mem_re_s;
  logic              in_range_s;
  logic [DATA_W-1:0] mem_q_s;

  assign in_range_s = addr_in_range(32'(addr_r), 32'(DEPTH));

  // State, counter, capture and response registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      addr_r    <= {ADDR_W{1'b0}};
      we_r      <= 1'b0;
      wdata_r   <= {DATA_W{1'b0}};
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      rd_zero_r <= 1'b1;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      addr_r    <= addr_s;
      we_r      <= we_s;
      wdata_r   <= wdata_s;
      ack_r     <= ack_s;
      err_r     <= err_s;
      busy_r    <= busy_s;
      rd_zero_r <= rd_zero_s;
    end
  end

  // Next-state logic: capture in IDLE (not while ack is up), count wait states, execute in ACCESS.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    addr_s    = addr_r;
    we_s      = we_r;
    wdata_s   = wdata_r;
    ack_s     = 1'b0;
    err_s     = 1'b0;
    rd_zero_s = rd_zero_r;
    mem_we_s  = 1'b0;
    mem_re_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req && !ack_r) begin
          addr_s  = bus.addr;
          we_s    = bus.we;
          wdata_s = bus.wdata;
          if (WAIT_STATES > 0) begin
            cnt_s   = CNT_W'(WAIT_STATES - 1);
            state_s = ST_WAIT;
          end else begin
            state_s = ST_ACCESS;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = ST_ACCESS;
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_ACCESS: begin
        ack_s   = 1'b1;
        state_s = ST_IDLE;
        if (in_range_s) begin
          if (we_r) begin
            mem_we_s = 1'b1;
          end else begin
            mem_re_s  = 1'b1;
            rd_zero_s = 1'b0;
          end
        end else begin
          err_s     = 1'b1;
          rd_zero_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we_s),
    .re    (mem_re_s),
    .idx   (addr_r[IDX_W-1:0]),
    .wdata (wdata_r),
    .rdata (mem_q_s)
  );

  // rdata reads as zero after reset or an out-of-range access, otherwise the last array read.
  assign bus.rdata = rd_zero_r ? {DATA_W{1'b0}} : mem_q_s;
  assign bus.ack   = ack_r;
  assign bus.err   = err_r;
  assign bus.busy  = busy_r;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: three instances (W=0/D=256, W=3/D=16,
// W=5/D=256). Stimulus pushes expected responses; a monitor pops on ack.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] res_v;
  logic [2:0] req_v;
  logic [2:0] we_v;
  logic [7:0] addr_v  [3];
  logic [7:0] wdata_v [3];
  logic [2:0] ack_v, err_v, busy_v;
  logic [7:0] rdata_v [3];

  data_mem_ctrl_if #(.DATA_W(8), .ADDR_W(8)) if0 ();
  data_mem_ctrl_if #(.DATA_W(8), .ADDR_W(8)) if1 ();
  data_mem_ctrl_if #(.DATA_W(8), .ADDR_W(8)) if2 ();

  assign if0.req = req_v[0]; assign if0.we = we_v[0]; assign if0.addr = addr_v[0]; assign if0.wdata = wdata_v[0];
  assign if1.req = req_v[1]; assign if1.we = we_v[1]; assign if1.addr = addr_v[1]; assign if1.wdata = wdata_v[1];
  assign if2.req = req_v[2]; assign if2.we = we_v[2]; assign if2.addr = addr_v[2]; assign if2.wdata = wdata_v[2];
  assign ack_v  = {if2.ack,  if1.ack,  if0.ack};
  assign err_v  = {if2.err,  if1.err,  if0.err};
  assign busy_v = {if2.busy, if1.busy, if0.busy};
  assign rdata_v[0] = if0.rdata;
  assign rdata_v[1] = if1.rdata;
  assign rdata_v[2] = if2.rdata;

  data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(0)) dut0 (.clk(clk), .res(res_v[0]), .bus(if0));
  data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(16),  .WAIT_STATES(3)) dut1 (.clk(clk), .res(res_v[1]), .bus(if1));
  data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(5)) dut2 (.clk(clk), .res(res_v[2]), .bus(if2));

  typedef struct {
    int         inst;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t       exp_q [$];
  exp_t       mon_e;
  int         total = 0;
  int         bad = 0;
  int         ack_cnt [3] = '{0, 0, 0};
  int         push_cnt [3] = '{0, 0, 0};
  logic [7:0] last_rd [3];
  logic [7:0] mdl [3][256];

  function automatic int wait_of(input int i);
    case (i)
      0: return 0;
      1: return 3;
      default: return 5;
    endcase
  endfunction

  function automatic int depth_of(input int i);
    case (i)
      1: return 16;
      default: return 256;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ack_v[i] === 1'b1) begin
        ack_cnt[i]++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL spurious_ack inst=%0d: got ack with rdata=%02h err=%b, expected no ack", i, rdata_v[i], err_v[i]);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.inst != i || rdata_v[i] !== mon_e.rdata || err_v[i] !== mon_e.err) begin
            bad++;
            $display("FAIL sb_resp inst=%0d: got rdata=%02h err=%b, expected inst=%0d rdata=%02h err=%b",
                     i, rdata_v[i], err_v[i], mon_e.inst, mon_e.rdata, mon_e.err);
          end
        end
      end
    end
  end

  // One access; with hold=1 the requester keeps req one cycle past the ack cycle,
  // which must be treated as a second request captured only after ack drops.
  task automatic do_acc(input int i, input logic w, input logic [7:0] a, input logic [7:0] d, input logic hold);
    exp_t e;
    int   n;
    int   bcnt;
    logic got;
    int   wst;
    wst = wait_of(i);
    e.inst = i;
    if (int'(a) >= depth_of(i)) begin
      e.rdata = 8'h00; e.err = 1'b1;
    end else if (w) begin
      e.rdata = last_rd[i]; e.err = 1'b0;
      mdl[i][a] = d;
    end else begin
      e.rdata = mdl[i][a]; e.err = 1'b0;
    end
    last_rd[i] = e.rdata;
    @(negedge clk);
    we_v[i] = w; addr_v[i] = a; wdata_v[i] = d; req_v[i] = 1'b1;
    exp_q.push_back(e); push_cnt[i]++;
    if (hold) begin
      exp_q.push_back(e); push_cnt[i]++;
    end
    @(posedge clk);
    n = 0; bcnt = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ack_v[i]) got = 1'b1;
      else if (busy_v[i]) bcnt++;
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", 32'(n), 32'(wst + 2));
    chk("busy_cycles", 32'(bcnt), 32'(wst + 1));
    @(posedge clk);
    @(negedge clk);
    chk("no_capture_in_ack_cycle", 32'(busy_v[i]), 32'd0);
    if (hold) begin
      @(posedge clk);
      @(negedge clk);
      chk("held_req_recaptured", 32'(busy_v[i]), 32'd1);
      req_v[i] = 1'b0;
      n = 0; got = 1'b0;
      while (!got && n < 40) begin
        @(negedge clk);
        n++;
        if (ack_v[i]) got = 1'b1;
      end
      chk("held_second_ack", 32'(got), 32'd1);
    end else begin
      req_v[i] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acks_before;
    res_v = 3'b111; req_v = 3'b000; we_v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = 8'h00; wdata_v[i] = 8'h00; last_rd[i] = 8'h00;
    end
    #100;
    for (int i = 0; i < 3; i++) begin
      chk("reset_rdata", 32'(rdata_v[i]), 32'd0);
      chk("reset_ack",   32'(ack_v[i]),   32'd0);
      chk("reset_err",   32'(err_v[i]),   32'd0);
      chk("reset_busy",  32'(busy_v[i]),  32'd0);
    end
    @(negedge clk);
    res_v = 3'b000;

    // W=0, DEPTH=256
    do_acc(0, 1'b1, 8'h10, 8'h5A, 1'b0);
    do_acc(0, 1'b0, 8'h10, 8'h00, 1'b0);
    do_acc(0, 1'b1, 8'hFF, 8'hC3, 1'b0);
    do_acc(0, 1'b0, 8'hFF, 8'h00, 1'b0);
    do_acc(0, 1'b0, 8'h10, 8'h00, 1'b1);
    do_acc(0, 1'b1, 8'h10, 8'h11, 1'b0);
    do_acc(0, 1'b0, 8'h10, 8'h00, 1'b0);

    // W=3, DEPTH=16
    do_acc(1, 1'b1, 8'h00, 8'h3C, 1'b0);
    do_acc(1, 1'b1, 8'h01, 8'hA5, 1'b0);
    do_acc(1, 1'b0, 8'h01, 8'h00, 1'b0);
    do_acc(1, 1'b1, 8'h20, 8'hFF, 1'b0);
    do_acc(1, 1'b0, 8'h20, 8'h00, 1'b0);
    do_acc(1, 1'b1, 8'h0F, 8'h99, 1'b0);
    do_acc(1, 1'b0, 8'h0F, 8'h00, 1'b0);
    do_acc(1, 1'b0, 8'h10, 8'h00, 1'b0);
    do_acc(1, 1'b0, 8'h00, 8'h00, 1'b0);

    // W=5: reset in the middle of a write discards it
    do_acc(2, 1'b1, 8'h02, 8'h00, 1'b0);
    do_acc(2, 1'b0, 8'h02, 8'h00, 1'b0);
    acks_before = ack_cnt[2];
    @(negedge clk);
    we_v[2] = 1'b1; addr_v[2] = 8'h02; wdata_v[2] = 8'h77; req_v[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_reset", 32'(busy_v[2]), 32'd1);
    res_v[2] = 1'b1; req_v[2] = 1'b0;
    #1;
    chk("busy_in_reset", 32'(busy_v[2]), 32'd0);
    repeat (2) @(negedge clk);
    res_v[2] = 1'b0;
    last_rd[2] = 8'h00;
    repeat (10) @(negedge clk);
    chk("reset_no_ack", 32'(ack_cnt[2]), 32'(acks_before));
    chk("post_reset_rdata", 32'(rdata_v[2]), 32'd0);
    do_acc(2, 1'b0, 8'h02, 8'h00, 1'b0);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("ack_count", 32'(ack_cnt[i]), 32'(push_cnt[i]));
    end
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
